// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet path.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StEop,
    StErrWait
  } state_e;

  typedef enum logic [2:0] {
    ErrOk     = 3'd0,
    ErrStuff  = 3'd1,
    ErrAlign  = 3'd2,
    ErrBabble = 3'd3,
    ErrShort  = 3'd4,
    ErrEop    = 3'd5
  } pkt_err_e;

  localparam int unsigned STUFF_RUN     = 6;
  localparam int unsigned MAX_BYTES_DEF = 1026;
  localparam int unsigned BYTE_CNT_W    = $clog2(MAX_BYTES_DEF + 1);

endpackage

// File: rtl/usb_rx_pkt_ctrl_if.sv
// Bit-stream, unstuffer and byte/status signals of the receive packet sequencer.
interface usb_rx_pkt_ctrl_if;
  import usb_rx_pkg::*;

  logic       rx_bit;
  logic       rx_valid;
  logic       rx_se0;
  logic       us_in_bit;
  logic       us_in_valid;
  logic       us_out_bit;
  logic       us_out_valid;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       pkt_start;
  logic       pkt_end;
  pkt_err_e   pkt_err;
  logic       pkt_active;

  modport master (
    output rx_bit, rx_valid, rx_se0, us_out_bit, us_out_valid,
    input  us_in_bit, us_in_valid, byte_data, byte_valid, pkt_start, pkt_end, pkt_err,
           pkt_active
  );

  modport slave (
    input  rx_bit, rx_valid, rx_se0, us_out_bit, us_out_valid,
    output us_in_bit, us_in_valid, byte_data, byte_valid, pkt_start, pkt_end, pkt_err,
           pkt_active
  );

endinterface

// File: rtl/usb_rx_sync_detect.sv
// Counts raw zeros while idle and flags the 1 that completes a valid SYNC.
module usb_rx_sync_detect #(
  parameter int unsigned SYNC_MIN_ZEROS = 6
) (
  input  logic clk,
  input  logic nRST,
  input  logic enable,
  input  logic rx_bit,
  input  logic rx_valid,
  input  logic rx_se0,
  output logic sync_ok
);
  localparam int unsigned     CntW   = $clog2(SYNC_MIN_ZEROS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SYNC_MIN_ZEROS);

  logic [CntW-1:0] zero_cnt_q;
  logic            data_beat;

  assign data_beat = enable && rx_valid && !rx_se0;
  assign sync_ok   = data_beat && rx_bit && (zero_cnt_q >= CntMax);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      zero_cnt_q <= '0;
    end else if (!enable) begin
      zero_cnt_q <= '0;
    end else if (data_beat) begin
      if (rx_bit)                    zero_cnt_q <= '0;
      else if (zero_cnt_q != CntMax) zero_cnt_q <= zero_cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Receive packet sequencer: SYNC gating, stuff checking, LSB-first byte assembly, EOP status.
// The bit unstuffer lives beside this block; it is reached through the us_* bus signals.
module usb_rx_pkt_ctrl
  import usb_rx_pkg::*;
#(
  parameter int unsigned SYNC_MIN_ZEROS = 6,
  parameter int unsigned MAX_BYTES      = MAX_BYTES_DEF
) (
  input logic              clk,
  input logic              nRST,
  usb_rx_pkt_ctrl_if.slave bus
);
  localparam logic [BYTE_CNT_W-1:0] MaxCnt = BYTE_CNT_W'(MAX_BYTES);
  localparam logic [2:0]            RunMax = 3'(STUFF_RUN);

  state_e                state_q;
  logic [2:0]            raw_ones_q, bit_cnt_q, bit_cnt_nx;
  logic [1:0]            se0_cnt_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_nx;
  logic [7:0]            shift_q, byte_data_q;
  logic                  discard_first_q, flush_q, disc_flush_q;
  logic                  us_in_bit_q, us_in_valid_q, byte_valid_q;
  logic                  pkt_start_q, pkt_end_q, pkt_active_q;
  pkt_err_e              pkt_err_q, eop_err;
  logic                  sync_ok, se0_beat, data_beat, out_side, take, byte_done, babble;

  usb_rx_sync_detect #(
    .SYNC_MIN_ZEROS(SYNC_MIN_ZEROS)
  ) u_sync (
    .clk     (clk),
    .nRST    (nRST),
    .enable  (state_q == StIdle),
    .rx_bit  (bus.rx_bit),
    .rx_valid(bus.rx_valid),
    .rx_se0  (bus.rx_se0),
    .sync_ok (sync_ok)
  );

  always_comb begin
    se0_beat  = bus.rx_valid && bus.rx_se0;
    data_beat = bus.rx_valid && !bus.rx_se0;
    // Bits forwarded just before SE0 still drain out of the unstuffer while in EOP.
    out_side  = (state_q == StData) || (state_q == StEop);
    take      = out_side && bus.us_out_valid && !discard_first_q && !disc_flush_q;
    byte_done = take && (bit_cnt_q == 3'd7);
    babble    = byte_done && (byte_cnt_q == MaxCnt);
    bit_cnt_nx  = take ? bit_cnt_q + 3'd1 : bit_cnt_q;
    byte_cnt_nx = (byte_done && !babble) ? byte_cnt_q + BYTE_CNT_W'(1) : byte_cnt_q;
    if (raw_ones_q == RunMax)       eop_err = ErrStuff;
    else if (se0_cnt_q < 2'd2)      eop_err = ErrEop;
    else if (bit_cnt_nx != 3'd0)    eop_err = ErrAlign;
    else if (byte_cnt_nx == '0)     eop_err = ErrShort;
    else                            eop_err = ErrOk;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q         <= StIdle;
      raw_ones_q      <= '0;
      bit_cnt_q       <= '0;
      se0_cnt_q       <= '0;
      byte_cnt_q      <= '0;
      shift_q         <= '0;
      byte_data_q     <= '0;
      discard_first_q <= 1'b0;
      flush_q         <= 1'b0;
      disc_flush_q    <= 1'b0;
      us_in_bit_q     <= 1'b0;
      us_in_valid_q   <= 1'b0;
      byte_valid_q    <= 1'b0;
      pkt_start_q     <= 1'b0;
      pkt_end_q       <= 1'b0;
      pkt_active_q    <= 1'b0;
      pkt_err_q       <= ErrOk;
    end else begin
      us_in_bit_q   <= 1'b0;
      us_in_valid_q <= 1'b0;
      byte_valid_q  <= 1'b0;
      pkt_start_q   <= 1'b0;
      pkt_end_q     <= 1'b0;
      flush_q       <= 1'b0;
      disc_flush_q  <= flush_q;

      if (out_side) begin
        if (bus.us_out_valid && !disc_flush_q) discard_first_q <= 1'b0;
        if (take) begin
          shift_q   <= {bus.us_out_bit, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_nx;
        end
        if (byte_done && !babble) begin
          byte_valid_q <= 1'b1;
          byte_data_q  <= {bus.us_out_bit, shift_q[7:1]};
        end
        byte_cnt_q <= byte_cnt_nx;
      end

      unique case (state_q)
        StIdle: begin
          if (sync_ok) begin
            us_in_bit_q     <= 1'b1;
            us_in_valid_q   <= 1'b1;
            discard_first_q <= 1'b1;
            raw_ones_q      <= 3'd1;
            bit_cnt_q       <= '0;
            byte_cnt_q      <= '0;
            se0_cnt_q       <= '0;
            shift_q         <= '0;
            pkt_start_q     <= 1'b1;
            pkt_active_q    <= 1'b1;
            state_q         <= StData;
          end
        end
        StData: begin
          if (babble) begin
            pkt_end_q    <= 1'b1;
            pkt_err_q    <= ErrBabble;
            pkt_active_q <= 1'b0;
            se0_cnt_q    <= '0;
            state_q      <= StErrWait;
          end else if (se0_beat) begin
            us_in_valid_q <= 1'b1;
            flush_q       <= 1'b1;
            se0_cnt_q     <= 2'd1;
            state_q       <= StEop;
          end else if (data_beat) begin
            if ((raw_ones_q == RunMax) && bus.rx_bit) begin
              pkt_end_q    <= 1'b1;
              pkt_err_q    <= ErrStuff;
              pkt_active_q <= 1'b0;
              se0_cnt_q    <= '0;
              state_q      <= StErrWait;
            end else begin
              us_in_bit_q   <= bus.rx_bit;
              us_in_valid_q <= 1'b1;
              raw_ones_q    <= (bus.rx_bit && raw_ones_q != RunMax) ? raw_ones_q + 3'd1 : 3'd0;
            end
          end
        end
        StEop: begin
          // A nonzero se0_cnt_q carried into ERR_WAIT marks the flush as already done.
          if (babble) begin
            pkt_end_q    <= 1'b1;
            pkt_err_q    <= ErrBabble;
            pkt_active_q <= 1'b0;
            state_q      <= StErrWait;
          end else if (se0_beat) begin
            if (se0_cnt_q != 2'd3) se0_cnt_q <= se0_cnt_q + 2'd1;
          end else if (data_beat) begin
            pkt_end_q    <= 1'b1;
            pkt_err_q    <= eop_err;
            pkt_active_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        StErrWait: begin
          if (se0_beat && se0_cnt_q == 2'd0) begin
            us_in_valid_q <= 1'b1;
            flush_q       <= 1'b1;
            se0_cnt_q     <= 2'd1;
          end else if (data_beat && se0_cnt_q != 2'd0) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.us_in_bit   = us_in_bit_q;
  assign bus.us_in_valid = us_in_valid_q;
  assign bus.byte_data   = byte_data_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.pkt_start   = pkt_start_q;
  assign bus.pkt_end     = pkt_end_q;
  assign bus.pkt_err     = pkt_err_q;
  assign bus.pkt_active  = pkt_active_q;

endmodule
